// File: rtl/rvv_backend_div_unit_elem_seq.sv
// Element sequencer feeding one 32-bit iterative divider.
// Takes a whole vector divide uop, walks its elements in order, and skips
// masked-off elements by copying vd_old. Active elements are sent to the
// divider one at a time. The selected quotient or remainder of each element
// is packed into a VLEN-wide result, which is returned with valid/ready.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   trap_flush_rvv      flush, highest priority; the same signal flushes the divider
//   uop_*               uop request: operands, mask, sew, signed/rem select
//   div_*               divider request (hold-valid) and result handshake
//   res_valid/ready     packed result handshake
//   res_data            packed result
module rvv_backend_div_unit_elem_seq #(
  parameter int unsigned VLEN      = 128,
  parameter int unsigned DIV_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   trap_flush_rvv,
  input  logic                   uop_valid,
  output logic                   uop_ready,
  input  logic [VLEN-1:0]        uop_vs2,
  input  logic [VLEN-1:0]        uop_vs1,
  input  logic [VLEN-1:0]        uop_vd_old,
  input  logic [VLEN/8-1:0]      uop_mask,
  input  logic [1:0]             uop_sew,
  input  logic                   uop_signed,
  input  logic                   uop_rem,
  output logic                   div_valid,
  output logic                   div_opcode,
  output logic [DIV_WIDTH-1:0]   div_dividend,
  output logic [DIV_WIDTH-1:0]   div_divisor,
  input  logic [DIV_WIDTH-1:0]   div_quotient,
  input  logic [DIV_WIDTH-1:0]   div_remainder,
  input  logic                   div_res_valid,
  output logic                   div_res_ready,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [VLEN-1:0]        res_data
);

  localparam int unsigned NB = VLEN / 8;
  localparam int unsigned IW = $clog2(NB);
  localparam int unsigned SW = IW + 3;
  localparam int unsigned DW = DIV_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e          r_state, w_state_nxt;
  logic [IW-1:0]   r_idx;
  logic [VLEN-1:0] r_vs2, r_vs1, r_vd_old, r_res;
  logic [NB-1:0]   r_mask;
  logic [1:0]      r_sew;
  logic            r_signed, r_rem;

  logic [SW-1:0]   w_shamt;
  logic [DW-1:0]   w_fmask, w_raw_a, w_raw_b, w_raw_old, w_wdata;
  logic            w_active, w_last, w_accept, w_adv;

  // Sign- or zero-extend an 8/16-bit element to the divider width.
  function automatic logic [DW-1:0] f_ext(input logic [DW-1:0] raw,
                                          input logic [1:0] sew,
                                          input logic sgn);
    case (sew)
      2'd0:    f_ext = {{(DW-8){sgn & raw[7]}}, raw[7:0]};
      2'd1:    f_ext = {{(DW-16){sgn & raw[15]}}, raw[15:0]};
      default: f_ext = raw;
    endcase
  endfunction

  // Bit offset and field mask of the current element.
  assign w_shamt = {r_idx, 3'b000} << r_sew;

  always_comb begin
    w_fmask = '1;
    case (r_sew)
      2'd0:    w_fmask = DW'(8'hFF);
      2'd1:    w_fmask = DW'(16'hFFFF);
      default: w_fmask = '1;
    endcase
  end

  assign w_raw_a   = DW'(r_vs2 >> w_shamt);
  assign w_raw_b   = DW'(r_vs1 >> w_shamt);
  assign w_raw_old = DW'(r_vd_old >> w_shamt);
  assign w_active  = r_mask[r_idx];
  assign w_last    = (r_idx == IW'((NB >> r_sew) - 1));
  assign w_wdata   = w_active ? (r_rem ? div_remainder : div_quotient) : w_raw_old;

  assign div_opcode   = r_signed;
  assign div_dividend = f_ext(w_raw_a, r_sew, r_signed);
  assign div_divisor  = f_ext(w_raw_b, r_sew, r_signed);
  assign res_data     = r_res;

  // Next state and handshake outputs; flush and reset silence everything.
  always_comb begin
    w_state_nxt   = r_state;
    uop_ready     = 1'b0;
    div_valid     = 1'b0;
    div_res_ready = 1'b0;
    res_valid     = 1'b0;
    w_accept      = 1'b0;
    w_adv         = 1'b0;
    if (trap_flush_rvv) begin
      w_state_nxt = S_IDLE;
    end else if (!rst) begin
      case (r_state)
        S_IDLE: begin
          uop_ready = 1'b1;
          if (uop_valid) begin
            w_accept    = 1'b1;
            w_state_nxt = S_RUN;
          end
        end
        S_RUN: begin
          if (w_active) begin
            div_valid     = 1'b1;
            div_res_ready = 1'b1;
            w_adv         = div_res_valid;
          end else begin
            w_adv = 1'b1;
          end
          if (w_adv && w_last) w_state_nxt = S_DONE;
        end
        S_DONE: begin
          res_valid = 1'b1;
          if (res_ready) w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // State, latched uop and result packing.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_res    <= '0;
      r_vs2    <= '0;
      r_vs1    <= '0;
      r_vd_old <= '0;
      r_mask   <= '0;
      r_sew    <= '0;
      r_signed <= 1'b0;
      r_rem    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (trap_flush_rvv) begin
        r_idx <= '0;
      end else if (w_accept) begin
        r_vs2    <= uop_vs2;
        r_vs1    <= uop_vs1;
        r_vd_old <= uop_vd_old;
        r_mask   <= uop_mask;
        r_sew    <= (uop_sew == 2'd3) ? 2'd2 : uop_sew;  // illegal SEW runs as 32b
        r_signed <= uop_signed;
        r_rem    <= uop_rem;
        r_idx    <= '0;
      end else if (w_adv) begin
        r_res <= (r_res & ~(VLEN'(w_fmask) << w_shamt))
               | (VLEN'(w_wdata & w_fmask) << w_shamt);
        r_idx <= w_last ? '0 : r_idx + IW'(1);
      end
    end
  end

  a_sew_legal: assert property (@(posedge clk) disable iff (rst)
    (uop_valid && uop_ready) |-> (uop_sew != 2'd3));

endmodule

// File: tb/tb_rvv_backend_div_unit_elem_seq.sv
// Bench for rvv_backend_div_unit_elem_seq: drives randomized and directed vector
// divide uops. It also stands in for the divider, with random result latency.
// An element-level model checks handshakes, operands and packed results on every cycle.
module tb_rvv_backend_div_unit_elem_seq;

  logic         clk = 1'b0;
  logic         rst, trap_flush_rvv, uop_valid, uop_ready;
  logic [127:0] uop_vs2, uop_vs1, uop_vd_old, res_data;
  logic [15:0]  uop_mask;
  logic [1:0]   uop_sew;
  logic         uop_signed, uop_rem;
  logic         div_valid, div_opcode, div_res_valid, div_res_ready;
  logic [31:0]  div_dividend, div_divisor, div_quotient, div_remainder;
  logic         res_valid, res_ready;

  rvv_backend_div_unit_elem_seq #(.VLEN(128), .DIV_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .trap_flush_rvv(trap_flush_rvv),
    .uop_valid(uop_valid), .uop_ready(uop_ready),
    .uop_vs2(uop_vs2), .uop_vs1(uop_vs1), .uop_vd_old(uop_vd_old),
    .uop_mask(uop_mask), .uop_sew(uop_sew), .uop_signed(uop_signed), .uop_rem(uop_rem),
    .div_valid(div_valid), .div_opcode(div_opcode),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_remainder(div_remainder),
    .div_res_valid(div_res_valid), .div_res_ready(div_res_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_fail = 0;

  // element-level model of the uop in flight
  int           m_phase = 0;  // 0 idle, 1 walking elements, 2 result offered
  int           m_pos, m_ne, m_w, m_cyc, m_done_cyc, m_act_done, m_done_cnt;
  logic [127:0] m_vs2, m_vs1, m_vdo, m_exp, last_res;
  logic [15:0]  m_mask;
  bit           m_s, m_r;
  int           rr_hold = 0, flush_at = -1;
  bit           force_flush = 0, rst_q = 0;

  // divider stand-in
  bit           dv_busy = 0, dv_s;
  int           dv_lat;
  logic [31:0]  dv_a, dv_b;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_fail++;
    $display("FAIL %s: bound expired, got no progress, expected completion", name);
  endtask

  function automatic logic [31:0] get_el(input logic [127:0] v, input int idx, input int w);
    logic [127:0] t;
    t = v >> (idx * w);
    return t[31:0] & (32'hFFFF_FFFF >> (32 - w));
  endfunction

  function automatic logic [31:0] ext_el(input logic [31:0] a, input int w, input bit s);
    logic [31:0] t;
    if (!s) return a;
    t = a << (32 - w);
    return $signed(t) >>> (32 - w);
  endfunction

  // RISC-V divide/remainder at element width, including /0 and overflow rules.
  function automatic logic [31:0] ref_el(input logic [31:0] a, input logic [31:0] b,
                                         input int w, input bit s, input bit r);
    longint sa, sb, q, rr;
    sa = longint'(a);
    sb = longint'(b);
    if (s && a[w-1]) sa = sa - (longint'(1) << w);
    if (s && b[w-1]) sb = sb - (longint'(1) << w);
    if (sb == 0) begin
      q = -1; rr = sa;
    end else if (s && sa == -(longint'(1) << (w - 1)) && sb == -1) begin
      q = sa; rr = 0;
    end else begin
      q = sa / sb; rr = sa % sb;
    end
    return 32'(r ? rr : q) & (32'hFFFF_FFFF >> (32 - w));
  endfunction

  // One clock cycle: drive, check pre-edge outputs, run divider, advance model.
  task automatic tick();
    bit acc, took, ret;
    if (m_phase == 2) res_ready = (m_done_cnt >= rr_hold);
    else              res_ready = 1'($urandom_range(0, 1));
    trap_flush_rvv = force_flush ||
      (flush_at >= 0 && m_phase == 1 && m_mask[m_pos] && m_act_done == flush_at);
    #2;
    if (rst) begin
      chk("rst_ctl", {uop_ready, res_valid, div_valid, div_res_ready}, 4'b0000);
      if (rst_q) chk("rst_data", res_data, 128'd0);
    end else if (trap_flush_rvv) begin
      chk("flush_ctl", {uop_ready, res_valid, div_valid, div_res_ready}, 4'b0000);
    end else begin
      case (m_phase)
        0: chk("idle_ctl", {uop_ready, res_valid, div_valid, div_res_ready}, 4'b1000);
        1: if (m_mask[m_pos]) begin
             chk("act_ctl", {uop_ready, res_valid, div_valid, div_res_ready, div_opcode},
                 {4'b0011, m_s});
             chk("dividend", div_dividend, ext_el(get_el(m_vs2, m_pos, m_w), m_w, m_s));
             chk("divisor", div_divisor, ext_el(get_el(m_vs1, m_pos, m_w), m_w, m_s));
           end else begin
             chk("skip_ctl", {uop_ready, res_valid, div_valid, div_res_ready}, 4'b0000);
           end
        default: begin
          chk("done_ctl", {uop_ready, res_valid, div_valid, div_res_ready}, 4'b0100);
          chk("res_data", res_data, m_exp);
          if (m_done_cnt == 0) begin
            m_done_cyc = m_cyc;
            last_res   = res_data;
          end
        end
      endcase
    end
    if (rst || trap_flush_rvv) begin
      dv_busy = 0;
      div_res_valid = 1'b0;
    end else begin
      if (!dv_busy && div_valid) begin
        dv_busy = 1; dv_a = div_dividend; dv_b = div_divisor; dv_s = div_opcode;
        dv_lat = $urandom_range(0, 3);
      end
      if (dv_busy) begin
        if (dv_lat == 0) begin
          div_res_valid = 1'b1;
          div_quotient  = ref_el(dv_a, dv_b, 32, dv_s, 1'b0);
          div_remainder = ref_el(dv_a, dv_b, 32, dv_s, 1'b1);
        end else begin
          dv_lat--;
        end
      end
    end
    acc  = uop_valid && uop_ready && !rst;
    took = div_res_valid && div_res_ready;
    ret  = res_valid && res_ready;
    @(posedge clk);
    #1;
    rst_q = rst;
    if (took) dv_busy = 0;
    div_res_valid = 1'b0;
    div_quotient  = $urandom;
    div_remainder = $urandom;
    if (rst || trap_flush_rvv) begin
      m_phase = 0;
    end else if (acc) begin
      m_vs2 = uop_vs2; m_vs1 = uop_vs1; m_vdo = uop_vd_old; m_mask = uop_mask;
      m_s = uop_signed; m_r = uop_rem;
      m_w = 8 << uop_sew; m_ne = 16 >> uop_sew;
      m_phase = 1; m_pos = 0; m_cyc = 0; m_act_done = 0; m_done_cnt = 0; m_done_cyc = -1;
      m_exp = '0;
      for (int i = 0; i < m_ne; i++)
        m_exp |= 128'(m_mask[i] ? ref_el(get_el(m_vs2, i, m_w), get_el(m_vs1, i, m_w),
                                         m_w, m_s, m_r)
                                : get_el(m_vdo, i, m_w)) << (i * m_w);
    end else begin
      m_cyc++;
      if (m_phase == 1) begin
        if (!m_mask[m_pos]) m_pos++;
        else if (took) begin m_pos++; m_act_done++; end
        if (m_pos == m_ne) m_phase = 2;
      end else if (m_phase == 2) begin
        if (ret) m_phase = 0;
        else     m_done_cnt++;
      end
    end
  endtask

  task automatic run_uop(input logic [127:0] a, input logic [127:0] b, input logic [127:0] o,
                         input logic [15:0] mk, input logic [1:0] sw, input bit s, input bit r,
                         input int hold, input int fl, input bit pre_flush);
    bit acc_ok = 0;
    uop_vs2 = a; uop_vs1 = b; uop_vd_old = o; uop_mask = mk; uop_sew = sw;
    uop_signed = s; uop_rem = r; uop_valid = 1'b1;
    rr_hold = hold; flush_at = fl;
    if (pre_flush) begin force_flush = 1; tick(); force_flush = 0; end
    for (int i = 0; i < 20 && !acc_ok; i++) begin
      tick();
      if (m_phase != 0) acc_ok = 1;
    end
    if (!acc_ok) fail_now("accept_timeout");
    uop_valid = 1'b0;
    uop_vs2 = {4{$urandom}}; uop_vs1 = {4{$urandom}}; uop_vd_old = {4{$urandom}};
    uop_mask = 16'($urandom); uop_signed = 1'($urandom); uop_rem = 1'($urandom);
    for (int i = 0; i < 600 && m_phase != 0; i++) tick();
    if (m_phase != 0) fail_now("retire_timeout");
    flush_at = -1;
  endtask

  // Random operands, with a bias toward divide-by-zero and signed-overflow pairs.
  task automatic rand_ops(input int sw, output logic [127:0] a, output logic [127:0] b);
    int w, ne;
    logic [31:0] x, y, m;
    w = 8 << sw; ne = 16 >> sw; m = 32'hFFFF_FFFF >> (32 - w);
    a = '0; b = '0;
    for (int i = 0; i < ne; i++) begin
      x = $urandom; y = $urandom;
      case ($urandom_range(0, 7))
        0: y = 0;
        1: begin x = 32'h1 << (w - 1); y = '1; end
        2: y = $urandom_range(1, 5);
        default: ;
      endcase
      a |= 128'(x & m) << (i * w);
      b |= 128'(y & m) << (i * w);
    end
  endtask

  initial begin
    logic [127:0] a, b, o;
    int sw;
    #200000;
    $display("FAIL watchdog: got no $finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [127:0] a, b, o;
    int sw;
    rst = 1'b1; trap_flush_rvv = 1'b0; uop_valid = 1'b0;
    uop_vs2 = '0; uop_vs1 = '0; uop_vd_old = '0; uop_mask = '0; uop_sew = '0;
    uop_signed = 1'b0; uop_rem = 1'b0; res_ready = 1'b0;
    div_res_valid = 1'b0; div_quotient = '0; div_remainder = '0;
    @(posedge clk); #1;
    rst_q = 1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // reference model pinned by hand-computed values
    chk("pin_s8_q", ref_el(32'h80, 32'hFF, 8, 1, 0), 32'h80);
    chk("pin_s8_r", ref_el(32'h80, 32'hFF, 8, 1, 1), 32'h00);
    chk("pin_u32_q", ref_el(32'd100, 32'd7, 32, 0, 0), 32'd14);
    chk("pin_u16_dz", ref_el(32'h1234, 32'h0, 16, 0, 0), 32'hFFFF);
    chk("pin_s32_r", ref_el(32'hFFFF_FFF7, 32'd2, 32, 1, 1), 32'hFFFF_FFFF);

    // SEW8 signed overflow in element 0
    a = {4{$urandom}}; b = {4{$urandom}}; a[7:0] = 8'h80; b[7:0] = 8'hFF;
    run_uop(a, b, '0, 16'hFFFF, 2'd0, 1, 0, 0, -1, 0);
    chk("t1_quot", 128'(last_res[7:0]), 128'h80);
    run_uop(a, b, '0, 16'hFFFF, 2'd0, 1, 1, 0, -1, 0);
    chk("t1_rem", 128'(last_res[7:0]), 128'h00);

    // SEW32 unsigned 100/7
    run_uop({4{32'd100}}, {4{32'd7}}, '0, 16'hFFFF, 2'd2, 0, 0, 1, -1, 0);
    chk("t2_quot", last_res, {4{32'd14}});
    run_uop({4{32'd100}}, {4{32'd7}}, '0, 16'hFFFF, 2'd2, 0, 1, 0, -1, 0);
    chk("t2_rem", last_res, {4{32'd2}});

    // SEW16 divide by zero
    run_uop({8{16'h1234}}, '0, '0, 16'hFFFF, 2'd1, 0, 0, 0, -1, 0);
    chk("t3_quot", last_res, {8{16'hFFFF}});
    run_uop({8{16'h1234}}, '0, '0, 16'hFFFF, 2'd1, 0, 1, 0, -1, 0);
    chk("t3_rem", last_res, {8{16'h1234}});

    // all elements masked off: vd_old passes through in 16 cycles
    o = {4{$urandom}};
    run_uop({4{$urandom}}, {4{$urandom}}, o, 16'h0000, 2'd0, 1, 0, 0, -1, 0);
    chk("t4_data", last_res, o);
    chk("t4_latency", 128'(m_done_cyc), 128'd16);

    // consumer stalls 10 cycles in DONE
    rand_ops(0, a, b);
    run_uop(a, b, {4{$urandom}}, 16'($urandom), 2'd0, 1, 0, 10, -1, 0);

    // flush on the third active element, then a uop offered during a flush
    rand_ops(0, a, b);
    run_uop(a, b, '0, 16'hFFFF, 2'd0, 0, 0, 0, 2, 0);
    run_uop({4{32'hFFFF_FFF7}}, {4{32'd2}}, '0, 16'hFFFF, 2'd2, 1, 0, 0, -1, 1);
    chk("t6_quot", last_res, {4{32'hFFFF_FFFC}});
    run_uop({4{32'hFFFF_FFF7}}, {4{32'd2}}, '0, 16'hFFFF, 2'd2, 1, 1, 0, -1, 0);
    chk("t6_rem", last_res, {4{32'hFFFF_FFFF}});

    // reset in the middle of a uop clears the result
    rand_ops(0, a, b);
    uop_vs2 = a; uop_vs1 = b; uop_vd_old = '1; uop_mask = 16'hFFFF; uop_sew = 2'd0;
    uop_signed = 1'b0; uop_rem = 1'b0; uop_valid = 1'b1;
    tick();
    uop_valid = 1'b0;
    repeat (20) tick();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // randomized uops
    for (int k = 0; k < 24; k++) begin
      sw = $urandom_range(0, 2);
      rand_ops(sw, a, b);
      run_uop(a, b, {4{$urandom}}, 16'($urandom), 2'(sw), 1'($urandom), 1'($urandom),
              $urandom_range(0, 3), -1, 0);
    end
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
